// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control FSM for the XM-23 core: owns PC, runs the shared
// memory handshake for instruction fetch and LD/ST data phases, halts and faults.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        Step,
  output logic        Mem_req,
  output logic        Mem_we,
  output logic [15:0] Mem_addr,
  input  logic [15:0] Mem_rdata,
  input  logic        Mem_ack,
  output logic [15:0] Instr,
  output logic        Dec_E,
  input  logic [6:0]  OP,
  input  logic        FLT,
  output logic        Exec_start,
  input  logic        Exec_done,
  input  logic [15:0] EA,
  input  logic        Br_taken,
  input  logic [15:0] Br_target,
  output logic [15:0] Ld_data,
  output logic        Ld_valid,
  output logic [15:0] PC,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] Instr_count
);

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 7;
  localparam int unsigned TW  = 8;

  localparam logic [OPW-1:0] OP_LD  = OPW'(33);
  localparam logic [OPW-1:0] OP_ST  = OPW'(34);
  localparam logic [OPW-1:0] OP_LDR = OPW'(39);
  localparam logic [OPW-1:0] OP_STR = OPW'(40);
  localparam logic [OPW-1:0] OP_BRK = OPW'(41);
  localparam logic [TW-1:0]  TMO_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DCHK, S_EXEC, S_MEM, S_HALT, S_FAULT
  } state_t;

  state_t         state_q, state_nxt;
  logic [OPW-1:0] op_q, op_nxt;
  logic [TW-1:0]  tmo_q, tmo_nxt;
  logic [DW-1:0]  pc_nxt, instr_nxt, addr_nxt, ld_data_nxt, count_nxt;
  logic           req_nxt, we_nxt, dec_e_nxt, start_nxt, ld_valid_nxt;
  logic           op_is_load, op_is_store;

  assign op_is_load  = (op_q == OP_LD) || (op_q == OP_LDR);
  assign op_is_store = (op_q == OP_ST) || (op_q == OP_STR);

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_nxt    = state_q;
    op_nxt       = op_q;
    tmo_nxt      = '0;
    pc_nxt       = PC;
    instr_nxt    = Instr;
    addr_nxt     = Mem_addr;
    ld_data_nxt  = Ld_data;
    count_nxt    = Instr_count;
    dec_e_nxt    = 1'b0;
    start_nxt    = 1'b0;
    ld_valid_nxt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run || Step) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (Mem_ack) begin
          instr_nxt = Mem_rdata;
          pc_nxt    = DW'(PC + 16'd2);
          dec_e_nxt = 1'b1;
          state_nxt = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_nxt = S_FAULT;
        end else begin
          tmo_nxt = TW'(tmo_q + 8'd1);
        end
      end
      S_DECODE: state_nxt = S_DCHK;
      S_DCHK: begin
        op_nxt = OP;
        if (FLT) begin
          state_nxt = S_FAULT;
        end else if (OP == OP_BRK) begin
          count_nxt = DW'(Instr_count + 16'd1);
          state_nxt = S_HALT;
        end else begin
          start_nxt = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (Exec_done) begin
          if (op_is_load || op_is_store) begin
            addr_nxt  = EA;
            state_nxt = S_MEM;
          end else begin
            if (Br_taken) pc_nxt = Br_target;
            count_nxt = DW'(Instr_count + 16'd1);
            state_nxt = Run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_MEM: begin
        if (Mem_ack) begin
          if (op_is_load) begin
            ld_data_nxt  = Mem_rdata;
            ld_valid_nxt = 1'b1;
          end
          count_nxt = DW'(Instr_count + 16'd1);
          state_nxt = Run ? S_FETCH : S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_nxt = S_FAULT;
        end else begin
          tmo_nxt = TW'(tmo_q + 8'd1);
        end
      end
      S_HALT: begin
        if (Step) state_nxt = S_FETCH;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase

    // Fetch address follows the (possibly redirected) PC; EA is held through MEM.
    if (state_nxt == S_FETCH) addr_nxt = pc_nxt;
    req_nxt = (state_nxt == S_FETCH) || (state_nxt == S_MEM);
    we_nxt  = (state_nxt == S_MEM) && op_is_store;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      tmo_q       <= '0;
      PC          <= RESET_PC;
      Instr       <= '0;
      Mem_addr    <= RESET_PC;
      Ld_data     <= '0;
      Instr_count <= '0;
      Mem_req     <= 1'b0;
      Mem_we      <= 1'b0;
      Dec_E       <= 1'b0;
      Exec_start  <= 1'b0;
      Ld_valid    <= 1'b0;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      op_q        <= op_nxt;
      tmo_q       <= tmo_nxt;
      PC          <= pc_nxt;
      Instr       <= instr_nxt;
      Mem_addr    <= addr_nxt;
      Ld_data     <= ld_data_nxt;
      Instr_count <= count_nxt;
      Mem_req     <= req_nxt;
      Mem_we      <= we_nxt;
      Dec_E       <= dec_e_nxt;
      Exec_start  <= start_nxt;
      Ld_valid    <= ld_valid_nxt;
      Halted      <= (state_nxt == S_HALT);
      Fault       <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: cycle-accurate memory/decoder/datapath
// responders driven from the stimulus thread, hand-computed expectations.
module tb_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n, Run, Step;
  logic        Mem_req, Mem_we, Mem_ack;
  logic [15:0] Mem_addr, Mem_rdata, Instr, EA, Br_target, Ld_data, PC, Instr_count;
  logic        Dec_E, FLT, Exec_start, Exec_done, Br_taken, Ld_valid, Halted, Fault;
  logic [6:0]  OP;

  instr_sequencer #(.RESET_PC(16'h0000), .MEM_TIMEOUT(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Step(Step),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_rdata(Mem_rdata),
    .Mem_ack(Mem_ack), .Instr(Instr), .Dec_E(Dec_E), .OP(OP), .FLT(FLT),
    .Exec_start(Exec_start), .Exec_done(Exec_done), .EA(EA), .Br_taken(Br_taken),
    .Br_target(Br_target), .Ld_data(Ld_data), .Ld_valid(Ld_valid), .PC(PC),
    .Halted(Halted), .Fault(Fault), .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] mem [logic [15:0]];
  bit   ack_en = 1'b1;
  int   ack_wait = 0;
  int   age = 0;
  bit   req_prev = 1'b0, ack_prev = 1'b0, exec_pend = 1'b0;
  int   req_seen = 0, ld_pulses = 0;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h4C01;
  endfunction

  // Bench-side decoder: {OP, FLT} for the instruction words used here.
  function automatic logic [7:0] decode(input logic [15:0] w);
    case (w)
      16'h4C01: return {7'd20, 1'b0};
      16'h5800: return {7'd33, 1'b0};
      16'h5C00: return {7'd34, 1'b0};
      16'h8000: return {7'd39, 1'b0};
      16'hC000: return {7'd40, 1'b0};
      16'h2000: return {7'd1,  1'b0};
      16'h5400: return {7'd41, 1'b0};
      default:  return {7'd0,  1'b1};
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; then respond to what the DUT presents for the next edge.
  task automatic tick();
    bit new_req;
    @(posedge Clock);
    #1;
    if (Mem_req) req_seen++;
    if (Ld_valid) ld_pulses++;
    new_req = Mem_req && (!req_prev || ack_prev);
    if (!Mem_req || new_req) age = 0;
    else age++;
    req_prev  = Mem_req;
    Mem_ack   = Mem_req && ack_en && (age >= ack_wait);
    ack_prev  = Mem_ack;
    Mem_rdata = Mem_ack ? rd(Mem_addr) : 16'h0000;
    Exec_done = exec_pend;
    exec_pend = Exec_start;
    if (Dec_E) {OP, FLT} = decode(Instr);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    Reset_n = 1'b0; Run = 1'b0; Step = 1'b0;
    Mem_ack = 1'b0; Mem_rdata = '0; OP = '0; FLT = 1'b0;
    Exec_done = 1'b0; EA = '0; Br_taken = 1'b0; Br_target = '0;
    mem[16'h0000] = 16'h4C01;
    mem[16'h0002] = 16'h5800;
    mem[16'h0004] = 16'h5C00;
    mem[16'h0006] = 16'hC000;
    mem[16'h0008] = 16'h2000;
    mem[16'h0100] = 16'h2000;
    mem[16'h0102] = 16'h5400;
    mem[16'h0108] = 16'h2000;
    mem[16'h1234] = 16'hBEEF;

    ticks(2);
    check("rst_pc", PC, 16'h0000);
    check("rst_instr", Instr, 16'h0000);
    check("rst_count", Instr_count, 16'h0000);
    check("rst_ld_data", Ld_data, 16'h0000);
    check("rst_req", 16'(Mem_req), 16'h0);
    check("rst_flags", {14'h0, Halted, Fault}, 16'h0);

    // MOV at 0000: 5 cycles from FETCH entry to next FETCH entry.
    Reset_n = 1'b1; Run = 1'b1;
    tick();
    check("f0_req", {15'h0, Mem_req}, 16'h1);
    check("f0_addr", Mem_addr, 16'h0000);
    tick();
    check("dec_e_on", 16'(Dec_E), 16'h1);
    check("f0_instr", Instr, 16'h4C01);
    check("f0_pc", PC, 16'h0002);
    tick();
    check("dec_e_off", 16'(Dec_E), 16'h0);
    ticks(3);
    check("mov_count", Instr_count, 16'h0001);
    check("f1_addr", Mem_addr, 16'h0002);
    check("f1_req", 16'(Mem_req), 16'h1);

    // LD: data phase at EA, load data returned with one Ld_valid pulse.
    EA = 16'h1234;
    ticks(5);
    check("ld_addr", Mem_addr, 16'h1234);
    check("ld_we", {15'h0, Mem_we}, 16'h0);
    check("ld_req", 16'(Mem_req), 16'h1);
    tick();
    check("ld_valid", 16'(Ld_valid), 16'h1);
    check("ld_data", Ld_data, 16'hBEEF);
    check("f2_addr", Mem_addr, 16'h0004);
    check("ld_count", Instr_count, 16'h0002);

    // ST and STR: writes at EA.
    EA = 16'h2000;
    ticks(5);
    check("st_addr", Mem_addr, 16'h2000);
    check("st_we", 16'(Mem_we), 16'h1);
    tick();
    check("st_no_ldv", 16'(Ld_valid), 16'h0);
    check("f3_addr", Mem_addr, 16'h0006);
    EA = 16'h2002;
    ticks(5);
    check("str_addr", Mem_addr, 16'h2002);
    check("str_we", 16'(Mem_we), 16'h1);
    tick();
    check("f4_addr", Mem_addr, 16'h0008);
    check("str_count", Instr_count, 16'h0004);

    // Branch taken, then not taken.
    Br_taken = 1'b1; Br_target = 16'h0100;
    ticks(5);
    check("br_t_addr", Mem_addr, 16'h0100);
    check("br_t_pc", PC, 16'h0100);
    Br_taken = 1'b0;
    ticks(5);
    check("br_n_addr", Mem_addr, 16'h0102);
    check("br_count", Instr_count, 16'h0006);
    check("ld_pulses", 16'(ld_pulses), 16'h0001);

    // BREAKPOINT at 0102: halt, no requests while Run stays high.
    ticks(3);
    check("brk_halted", 16'(Halted), 16'h1);
    check("brk_pc", PC, 16'h0104);
    check("brk_count", Instr_count, 16'h0007);
    req_seen = 0;
    ticks(20);
    check("halt_no_req", 16'(req_seen), 16'h0000);
    check("halt_stays", 16'(Halted), 16'h1);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("resume_halted", 16'(Halted), 16'h0);
    check("resume_addr", Mem_addr, 16'h0104);
    check("resume_req", 16'(Mem_req), 16'h1);

    // Run dropped mid-instruction: completes, then idles.
    Run = 1'b0;
    ticks(5);
    check("runoff_count", Instr_count, 16'h0008);
    check("runoff_req", 16'(Mem_req), 16'h0);
    ticks(3);
    check("idle_req", 16'(Mem_req), 16'h0);

    // Single step from IDLE: exactly one instruction.
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("step_addr", Mem_addr, 16'h0106);
    check("step_req", 16'(Mem_req), 16'h1);
    ticks(10);
    check("step_count", Instr_count, 16'h0009);
    check("step_idle_req", 16'(Mem_req), 16'h0);
    check("step_pc", PC, 16'h0108);

    // PC wrap: branch to FFFE, fetch there wraps PC to 0000.
    Br_taken = 1'b1; Br_target = 16'hFFFE; Run = 1'b1;
    tick();
    check("wrap_br_addr", Mem_addr, 16'h0108);
    ticks(5);
    check("wrap_addr", Mem_addr, 16'hFFFE);
    Br_taken = 1'b0;
    tick();
    check("wrap_pc", PC, 16'h0000);
    ticks(4);
    check("wrap_next_addr", Mem_addr, 16'h0000);
    check("wrap_count", Instr_count, 16'h000B);

    // Reset in the middle of a stalled LD data phase.
    ticks(5);
    check("mm_fetch_addr", Mem_addr, 16'h0002);
    ack_en = 1'b0; EA = 16'h3000;
    ticks(5);
    check("mm_addr", Mem_addr, 16'h3000);
    check("mm_req", 16'(Mem_req), 16'h1);
    Reset_n = 1'b0;
    tick();
    check("mm_rst_req", 16'(Mem_req), 16'h0);
    check("mm_rst_pc", PC, 16'h0000);
    check("mm_rst_count", Instr_count, 16'h0000);

    // Ack on the last allowed cycle succeeds; then decoder fault.
    mem[16'h0002] = 16'hFFFF;
    ack_en = 1'b1; ack_wait = 3; Reset_n = 1'b1;
    ticks(4);
    check("lim_req", 16'(Mem_req), 16'h1);
    check("lim_fault_pre", 16'(Fault), 16'h0);
    tick();
    check("lim_ok_fault", 16'(Fault), 16'h0);
    check("lim_ok_dec", 16'(Dec_E), 16'h1);
    check("lim_ok_pc", PC, 16'h0002);
    ack_wait = 0;
    ticks(4);
    check("flt_fetch_addr", Mem_addr, 16'h0002);
    ticks(3);
    check("flt_fault", 16'(Fault), 16'h1);
    check("flt_req", 16'(Mem_req), 16'h0);
    check("flt_count", Instr_count, 16'h0001);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    ticks(5);
    check("flt_sticky", 16'(Fault), 16'h1);
    check("flt_sticky_req", 16'(Mem_req), 16'h0);
    Reset_n = 1'b0;
    tick();
    check("flt_rst", 16'(Fault), 16'h0);

    // Memory timeout: no ack for MEM_TIMEOUT=4 cycles.
    ack_en = 1'b0; Reset_n = 1'b1;
    ticks(4);
    check("tmo_pre_fault", 16'(Fault), 16'h0);
    check("tmo_pre_req", 16'(Mem_req), 16'h1);
    tick();
    check("tmo_fault", 16'(Fault), 16'h1);
    check("tmo_req", 16'(Mem_req), 16'h0);
    ack_en = 1'b1;
    ticks(10);
    check("tmo_sticky", 16'(Fault), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
